// File: rtl/cdb_scheduler.sv
// cdb_scheduler: Common Data Bus arbiter with a one-entry output register.
// The max-priority EU normally wins. A saturating streak counter forces a
// round-robin low-priority grant once the max-priority EU has won MAX_STREAK
// times in a row while low-priority requesters were waiting.
module cdb_scheduler #(
  parameter int N_LP       = 4,
  parameter int DATA_W     = 72,
  parameter int MAX_STREAK = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       max_prio_valid_i,
  output logic                       max_prio_ready_o,
  input  logic [DATA_W-1:0]          max_prio_data_i,
  input  logic [N_LP-1:0]            valid_i,
  output logic [N_LP-1:0]            ready_o,
  input  logic [N_LP*DATA_W-1:0]     lp_data_i,
  output logic                       rob_valid_o,
  input  logic                       rob_ready_i,
  output logic [DATA_W-1:0]          rob_data_o,
  output logic [$clog2(N_LP+1)-1:0]  served_o
);

  localparam int PTR_W = (N_LP > 1) ? $clog2(N_LP) : 1;
  localparam int STR_W = $clog2(MAX_STREAK + 1);
  localparam int SRV_W = $clog2(N_LP + 1);

  logic              rob_valid_reg;
  logic [DATA_W-1:0] rob_data_reg;
  logic [SRV_W-1:0]  served_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [STR_W-1:0]  streak_reg;

  logic [DATA_W-1:0] lp_data_arr [N_LP];
  logic [N_LP-1:0]   upper_req;
  logic [PTR_W-1:0]  lp_win;
  logic              en;
  logic              blocked;
  logic              any_lp;
  logic              starving;
  logic              grant_max;
  logic              grant_lp;

  // Lowest set bit of a request vector (0 when empty; callers guard on non-empty).
  function automatic logic [PTR_W-1:0] lowest_set(input logic [N_LP-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = N_LP - 1; i >= 0; i--) begin
      if (v[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  // Unpack the flat payload bus and mark requests at or above the RR pointer.
  for (genvar gi = 0; gi < N_LP; gi++) begin : g_lp
    assign lp_data_arr[gi] = lp_data_i[gi*DATA_W +: DATA_W];
    assign upper_req[gi]   = valid_i[gi] && (PTR_W'(gi) >= rr_ptr_reg);
  end

  assign en       = !rob_valid_reg || rob_ready_i;
  assign blocked  = rst_i || flush_i;
  assign any_lp   = |valid_i;
  assign starving = any_lp && (streak_reg == STR_W'(MAX_STREAK));

  // Round robin: first request at or above rr_ptr, otherwise wrap to the lowest one.
  always_comb begin
    lp_win = '0;
    if (|upper_req) lp_win = lowest_set(upper_req);
    else            lp_win = lowest_set(valid_i);
  end

  // Winner selection; starvation override beats the max-priority EU.
  always_comb begin
    grant_max = 1'b0;
    grant_lp  = 1'b0;
    if (!blocked && en) begin
      if (starving)              grant_lp  = 1'b1;
      else if (max_prio_valid_i) grant_max = 1'b1;
      else if (any_lp)           grant_lp  = 1'b1;
    end
  end

  // Combinational one-hot accept strobes.
  always_comb begin
    ready_o = '0;
    if (grant_lp) ready_o[lp_win] = 1'b1;
    max_prio_ready_o = grant_max;
  end

  // Output register, round-robin pointer and streak counter.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rob_valid_reg <= 1'b0;
      rob_data_reg  <= '0;
      served_reg    <= '0;
      rr_ptr_reg    <= '0;
      streak_reg    <= '0;
    end else if (en) begin
      rob_valid_reg <= grant_max || grant_lp;
      if (grant_max) begin
        rob_data_reg <= max_prio_data_i;
        served_reg   <= '0;
        if (any_lp) begin
          if (streak_reg != STR_W'(MAX_STREAK)) streak_reg <= streak_reg + STR_W'(1);
        end else begin
          streak_reg <= '0;
        end
      end else if (grant_lp) begin
        rob_data_reg <= lp_data_arr[lp_win];
        served_reg   <= SRV_W'(lp_win) + SRV_W'(1);
        streak_reg   <= '0;
        rr_ptr_reg   <= (lp_win == PTR_W'(N_LP - 1)) ? '0 : lp_win + PTR_W'(1);
      end
    end
  end

  assign rob_valid_o = rob_valid_reg;
  assign rob_data_o  = rob_data_reg;
  assign served_o    = served_reg;

endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed stimulus with a scoreboard queue. Each step
// states the hand-computed winner; the monitor pops and compares whenever the
// ROB side completes a handshake.
module tb_cdb_scheduler;

  localparam int N_LP   = 4;
  localparam int DATA_W = 72;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    flush_i;
  logic                    max_prio_valid_i;
  logic                    max_prio_ready_o;
  logic [DATA_W-1:0]       max_prio_data_i;
  logic [N_LP-1:0]         valid_i;
  logic [N_LP-1:0]         ready_o;
  logic [N_LP*DATA_W-1:0]  lp_data_i;
  logic                    rob_valid_o;
  logic                    rob_ready_i;
  logic [DATA_W-1:0]       rob_data_o;
  logic [2:0]              served_o;

  typedef struct packed {
    logic [2:0]        srv;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   step_no   = 0;

  cdb_scheduler #(.N_LP(4), .DATA_W(72), .MAX_STREAK(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .max_prio_valid_i (max_prio_valid_i),
    .max_prio_ready_o (max_prio_ready_o),
    .max_prio_data_i  (max_prio_data_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .lp_data_i        (lp_data_i),
    .rob_valid_o      (rob_valid_o),
    .rob_ready_i      (rob_ready_i),
    .rob_data_o       (rob_data_o),
    .served_o         (served_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: every accepted ROB transfer must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && rob_valid_o && rob_ready_i) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got served=%0d data=%0h, required none", served_o, rob_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_served", 128'(served_o), 128'(e.srv));
        check("out_data", 128'(rob_data_o), 128'(e.data));
        $display("OUT served=%0d data=%0h", served_o, rob_data_o);
      end
    end
  end

  // One cycle of stimulus. exp: -1 no grant, 0 max prio, k+1 requester k.
  // chk: 0 nothing, 1 output held stable, 2 output register empty.
  task automatic step(input logic mpv, input logic [3:0] vld, input logic rr,
                      input logic fl, input int exp, input int chk);
    logic [3:0] exp_rdy;
    logic       exp_mp;
    exp_t       e;
    @(posedge clk_i);
    #1;
    step_no++;
    rst_i            = 1'b0;
    flush_i          = fl;
    max_prio_valid_i = mpv;
    valid_i          = vld;
    rob_ready_i      = rr;
    max_prio_data_i  = {8'hF0, 64'(step_no)};
    for (int k = 0; k < N_LP; k++)
      lp_data_i[k*DATA_W +: DATA_W] = {8'(8'h10 + k), 64'(step_no)};
    #3;
    exp_mp  = (exp == 0);
    exp_rdy = '0;
    if (exp > 0) exp_rdy[exp-1] = 1'b1;
    check("grant", 128'({max_prio_ready_o, ready_o}), 128'({exp_mp, exp_rdy}));
    $display("STEP %0d mpv=%b vld=%b rr=%b fl=%b -> mp_rdy=%b rdy=%b (want %b %b)",
             step_no, mpv, vld, rr, fl, max_prio_ready_o, ready_o, exp_mp, exp_rdy);
    if (chk == 1) begin
      check("hold_valid", 128'(rob_valid_o), 128'(1));
      check("hold_served", 128'(served_o), 128'(last_exp.srv));
      check("hold_data", 128'(rob_data_o), 128'(last_exp.data));
    end else if (chk == 2) begin
      check("empty_valid", 128'(rob_valid_o), 128'(0));
    end
    if (exp >= 0) begin
      e.srv  = 3'(exp);
      e.data = (exp == 0) ? max_prio_data_i : lp_data_i[(exp-1)*DATA_W +: DATA_W];
      exp_q.push_back(e);
      last_exp = e;
    end
    // A flushed entry never reaches the ROB.
    if (fl && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  initial begin
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    max_prio_valid_i = 1'b1;
    valid_i          = 4'b1111;
    rob_ready_i      = 1'b1;
    max_prio_data_i  = {8'hF0, 64'h0};
    lp_data_i        = '1;
    last_exp         = '0;
    repeat (2) @(posedge clk_i);
    #4;
    check("rst_ready", 128'({max_prio_ready_o, ready_o}), 128'(0));
    check("rst_valid", 128'(rob_valid_o), 128'(0));
    check("rst_served", 128'(served_o), 128'(0));
    check("rst_data", 128'(rob_data_o), 128'(0));

    // First grant after reset goes to max prio (streak -> 1).
    step(1, 4'b1111, 1, 0, 0, 0);
    // Round robin 1,2,3,4,1 (rr_ptr ends at 1).
    step(0, 4'b1111, 1, 0, 1, 0);
    step(0, 4'b1111, 1, 0, 2, 0);
    step(0, 4'b1111, 1, 0, 3, 0);
    step(0, 4'b1111, 1, 0, 4, 0);
    step(0, 4'b1111, 1, 0, 1, 0);
    // Starvation: four max grants, then requester 2, then max again.
    repeat (4) step(1, 4'b0100, 1, 0, 0, 0);
    step(1, 4'b0100, 1, 0, 3, 0);
    step(1, 4'b0100, 1, 0, 0, 0);
    step(1, 4'b0000, 1, 0, 0, 0);
    // Wrap from rr_ptr=3 with requesters 0 and 1.
    step(0, 4'b0011, 1, 0, 1, 0);
    step(0, 4'b0011, 1, 0, 2, 0);
    // Backpressure: fill, hold five cycles, then same-cycle regrant.
    step(1, 4'b0000, 1, 0, 0, 0);
    repeat (5) step(1, 4'b1111, 0, 0, -1, 1);
    step(1, 4'b1111, 1, 0, 0, 0);
    // Flush while full with requests pending.
    step(1, 4'b1111, 0, 1, -1, 1);
    // After flush: empty, streak restarts at 0 and rr_ptr at 0.
    step(1, 4'b1010, 1, 0, 0, 2);
    repeat (3) step(1, 4'b1010, 1, 0, 0, 0);
    step(1, 4'b1010, 1, 0, 2, 0);
    // Drain.
    step(0, 4'b0000, 1, 0, -1, 0);
    step(0, 4'b0000, 1, 0, -1, 2);

    check("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
